// File: rtl/cu_data_write_engine_pkg.sv
// rtl/cu_data_write_engine_pkg.sv - shared CU types, job descriptor, FSM states and helper functions
//
// Provides: DataRead / DataWrite beat records, cu_id_t, job_desc_t,
// wr_state_t, swap_endianness_data_write() and cmd_size_calculate().
package cu_pkg;

    localparam int DATA_SIZE_READ  = 8;
    localparam int DATA_SIZE_WRITE = DATA_SIZE_READ;
    localparam int ARRAY_SIZE      = 4;
    localparam int ARRAY_SIZE_BITS = 8;
    localparam int CU_ID_BITS      = 4;
    localparam int CMD_SIZE_MAX    = 128;

    typedef logic [CU_ID_BITS-1:0]      cu_id_t;
    typedef logic [ARRAY_SIZE_BITS-1:0] array_index_t;

    typedef struct packed {
        logic                        valid;
        cu_id_t                      cu_id;
        logic [DATA_SIZE_READ*8-1:0] data;
    } DataRead;

    typedef struct packed {
        logic                         valid;
        cu_id_t                       cu_id;
        array_index_t                 index;
        logic [DATA_SIZE_WRITE*8-1:0] data;
    } DataWrite;

    typedef struct packed {
        cu_id_t       cu_id;
        array_index_t base_index;
        array_index_t num_elements;
    } job_desc_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } wr_state_t;

    // Full byte reversal of a read beat into write byte order.
    function automatic logic [DATA_SIZE_WRITE*8-1:0] swap_endianness_data_write(
        input logic [DATA_SIZE_READ*8-1:0] d
    );
        logic [DATA_SIZE_WRITE*8-1:0] r;
        r = '0;
        for (int i = 0; i < DATA_SIZE_WRITE; i++) begin
            r[i*8 +: 8] = d[(DATA_SIZE_READ-1-i)*8 +: 8];
        end
        return r;
    endfunction

    // Smallest power of two >= nbytes, capped at CMD_SIZE_MAX; 0 for 0 bytes.
    function automatic logic [11:0] cmd_size_calculate(input int nbytes);
        logic [11:0] s;
        s = 12'd0;
        if (nbytes > 0) begin
            s = 12'd1;
            for (int i = 0; i < 7; i++) begin
                if (int'(s) < nbytes && int'(s) < CMD_SIZE_MAX) begin
                    s = s << 1;
                end
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/cu_data_write_engine_fifo_data_read.sv
// rtl/cu_data_write_engine_fifo_data_read.sv - synchronous FIFO of DataRead beats
//
// Ports: clock, rstn (async active-low), flush (drop all entries),
// push/din, pop/dout (dout shows head entry), full, empty.
// A push on a full FIFO is accepted only when a pop frees a slot in the same cycle.
module fifo_data_read
    import cu_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic    clock,
    input  logic    rstn,
    input  logic    flush,
    input  logic    push,
    input  DataRead din,
    input  logic    pop,
    output DataRead dout,
    output logic    full,
    output logic    empty
);

    localparam int AW = $clog2(DEPTH);

    DataRead         mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cu_data_write_engine.sv
// rtl/cu_data_write_engine.sv - buffers DataRead beats of one job and emits byte-swapped, indexed DataWrite records
//
// Ports: clock, rstn (async active-low), enabled, start + job_{cu_id,base_index,num_elements},
// read_data_in / read_ready (FIFO not full), write_data_out / write_cmd_size / write_ready,
// busy, done (one-cycle pulse), overflow_error (sticky).
module cu_data_write_engine
    import cu_pkg::*;
#(
    parameter int DATA_BYTES = DATA_SIZE_READ,
    parameter int ELEM_BYTES = ARRAY_SIZE,
    parameter int FIFO_DEPTH = 16
) (
    input  logic         clock,
    input  logic         rstn,
    input  logic         enabled,
    input  logic         start,
    input  cu_id_t       job_cu_id,
    input  array_index_t job_base_index,
    input  array_index_t job_num_elements,
    input  DataRead      read_data_in,
    output logic         read_ready,
    output DataWrite     write_data_out,
    output logic [11:0]  write_cmd_size,
    input  logic         write_ready,
    output logic         busy,
    output logic         done,
    output logic         overflow_error
);

    localparam array_index_t ELEMS_PER_BEAT = array_index_t'(DATA_BYTES / ELEM_BYTES);

    wr_state_t    state;
    wr_state_t    state_next;
    // base_index advances by each record's element count, so it always holds the
    // index of the next record; num_elements counts down as the remaining elements.
    job_desc_t    job;
    DataRead      fifo_dout;
    logic         fifo_full;
    logic         fifo_empty;
    logic         push;
    logic         pop;
    logic         job_accept;
    logic         final_accept;
    array_index_t n_elems;

    assign job_accept   = (state == ST_IDLE) && start && enabled;
    assign push         = read_data_in.valid && (read_data_in.cu_id == job.cu_id) && (state == ST_RUN);
    // Surplus beats after the last element stay queued until the DONE flush.
    assign pop          = enabled && !fifo_empty && (state == ST_RUN) && (job.num_elements != '0)
                          && (!write_data_out.valid || write_ready);
    assign n_elems      = (job.num_elements < ELEMS_PER_BEAT) ? job.num_elements : ELEMS_PER_BEAT;
    // A valid record with nothing left to issue can only be the job's final record.
    assign final_accept = (state == ST_RUN) && write_data_out.valid && write_ready
                          && (job.num_elements == '0);

    assign read_ready = !fifo_full;
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE);

    fifo_data_read #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .rstn  (rstn),
        .flush (state == ST_DONE),
        .push  (push),
        .din   (read_data_in),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (job_accept) begin
                    state_next = (job_num_elements == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (final_accept) state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            job            <= '0;
            write_data_out <= '0;
            write_cmd_size <= '0;
            overflow_error <= 1'b0;
        end else begin
            if (job_accept) begin
                job <= '{cu_id: job_cu_id, base_index: job_base_index, num_elements: job_num_elements};
            end else if (pop) begin
                job.base_index   <= job.base_index + n_elems;
                job.num_elements <= job.num_elements - n_elems;
            end

            // FIFO entries only ever hold beats of the current job's cu_id.
            if (pop) begin
                write_data_out <= '{valid: fifo_dout.valid,
                                   cu_id: fifo_dout.cu_id,
                                   index: job.base_index,
                                   data:  swap_endianness_data_write(fifo_dout.data)};
                write_cmd_size <= cmd_size_calculate(int'(n_elems) * ELEM_BYTES);
            end else if (write_ready) begin
                write_data_out.valid <= 1'b0;
            end

            if (push && fifo_full && !pop) begin
                overflow_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cu_data_write_engine.sv
// tb/tb_cu_data_write_engine.sv - randomized self-checking bench for cu_data_write_engine
module tb_cu_data_write_engine;
    import cu_pkg::*;

    localparam int EB  = 4;
    localparam int EPB = 2;

    logic         clock = 1'b0;
    logic         rstn;
    logic         enabled;
    logic         start;
    cu_id_t       job_cu_id;
    array_index_t job_base_index;
    array_index_t job_num_elements;
    DataRead      read_data_in;
    logic         read_ready;
    DataWrite     write_data_out;
    logic [11:0]  write_cmd_size;
    logic         write_ready;
    logic         busy;
    logic         done;
    logic         overflow_error;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int last_acc_cyc = -1;

    DataWrite     got_q[$];
    logic [11:0]  got_sz[$];
    int           got_cyc[$];
    logic [63:0]  beat_q[$];
    array_index_t exp_idx[$];
    logic [63:0]  exp_data[$];
    int           exp_sz[$];

    cu_data_write_engine #(
        .DATA_BYTES (8),
        .ELEM_BYTES (4),
        .FIFO_DEPTH (16)
    ) dut (
        .clock            (clock),
        .rstn             (rstn),
        .enabled          (enabled),
        .start            (start),
        .job_cu_id        (job_cu_id),
        .job_base_index   (job_base_index),
        .job_num_elements (job_num_elements),
        .read_data_in     (read_data_in),
        .read_ready       (read_ready),
        .write_data_out   (write_data_out),
        .write_cmd_size   (write_cmd_size),
        .write_ready      (write_ready),
        .busy             (busy),
        .done             (done),
        .overflow_error   (overflow_error)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (rstn) begin
            if (write_data_out.valid && write_ready) begin
                got_q.push_back(write_data_out);
                got_sz.push_back(write_cmd_size);
                got_cyc.push_back(cyc);
                last_acc_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    function automatic logic [63:0] ref_swap(input logic [63:0] d);
        logic [63:0] r;
        r = '0;
        for (int b = 0; b < 8; b++) r = (r << 8) | ((d >> (8*b)) & 64'hFF);
        return r;
    endfunction

    function automatic int ref_size(input int nbytes);
        int s;
        if (nbytes == 0) return 0;
        s = 1;
        while (s < nbytes) s = s * 2;
        if (s > 128) s = 128;
        return s;
    endfunction

    // Expected records: beats consumed in order, each carrying up to EPB elements.
    function automatic void model_job(input int base, input int count);
        int elem;
        int n;
        elem = 0;
        exp_idx.delete(); exp_data.delete(); exp_sz.delete();
        foreach (beat_q[i]) begin
            if (elem >= count) break;
            n = count - elem;
            if (n > EPB) n = EPB;
            exp_idx.push_back(array_index_t'((base + elem) % (1 << ARRAY_SIZE_BITS)));
            exp_data.push_back(ref_swap(beat_q[i]));
            exp_sz.push_back(ref_size(n * EB));
            elem += n;
        end
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_obs();
        got_q.delete(); got_sz.delete(); got_cyc.delete(); beat_q.delete();
    endtask

    task automatic start_job(input int id, input int base, input int count);
        start            = 1'b1;
        job_cu_id        = cu_id_t'(id);
        job_base_index   = array_index_t'(base);
        job_num_elements = array_index_t'(count);
        step();
        start = 1'b0;
    endtask

    task automatic send_beat(input int id, input logic [63:0] d);
        read_data_in = '{valid: 1'b1, cu_id: cu_id_t'(id), data: d};
        step();
        read_data_in.valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rand_ready, input int base_cnt, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < budget; t++) begin
            if (done_cnt > base_cnt) begin ok = 1'b1; break; end
            if (rand_ready) write_ready = 1'($urandom % 2);
            step();
        end
        if (done_cnt > base_cnt) ok = 1'b1;
        write_ready = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #1;
        n_checks++;
        if (write_data_out !== '0 || write_cmd_size !== 12'd0 || busy !== 1'b0 || done !== 1'b0
            || overflow_error !== 1'b0 || read_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_values wd=%h sz=%0d busy=%b done=%b ovf=%b rr=%b want all zero, rr=1",
                     write_data_out, write_cmd_size, busy, done, overflow_error, read_ready);
        end
        step(); step();
        rstn = 1'b1;
        step();
    endtask

    task automatic test_basic();
        bit ok;
        int bcnt;
        int p;
        clear_obs();
        write_ready = 1'b1;
        bcnt = done_cnt;
        start_job(3, 'h10, 5);
        p = cyc;
        for (int i = 0; i < 3; i++) begin
            beat_q.push_back(64'h0011223344556677);
            send_beat(3, 64'h0011223344556677);
        end
        wait_done(50, 1'b0, bcnt, ok);
        model_job('h10, 5);
        n_checks++;
        if (!ok || got_q.size() != 3) begin
            n_fail++;
            $display("FAIL basic_count records=%0d done_seen=%0b want 3 records and done", got_q.size(), ok);
        end
        for (int i = 0; i < got_q.size() && i < exp_idx.size(); i++) begin
            n_checks++;
            if (got_q[i].index !== exp_idx[i] || got_q[i].data !== exp_data[i]
                || got_sz[i] !== 12'(exp_sz[i]) || got_q[i].cu_id !== 4'd3) begin
                n_fail++;
                $display("FAIL basic_rec%0d got idx=%h data=%h sz=%0d id=%0d want idx=%h data=%h sz=%0d id=3",
                         i, got_q[i].index, got_q[i].data, got_sz[i], got_q[i].cu_id,
                         exp_idx[i], exp_data[i], exp_sz[i]);
            end
        end
        n_checks++;
        if (got_cyc.size() == 0 || got_cyc[0] != p + 2) begin
            n_fail++;
            $display("FAIL basic_latency first record cycle=%0d want %0d",
                     (got_cyc.size() > 0) ? got_cyc[0] : -1, p + 2);
        end
        n_checks++;
        if (done_cyc != last_acc_cyc + 1) begin
            n_fail++;
            $display("FAIL basic_done_timing done cycle=%0d want %0d", done_cyc, last_acc_cyc + 1);
        end
        step(); step();
        n_checks++;
        if (done_cnt - bcnt != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_pulse pulses=%0d busy=%b want 1 pulse, busy 0", done_cnt - bcnt, busy);
        end
    endtask

    task automatic test_zero_count();
        int s;
        int bcnt;
        clear_obs();
        bcnt = done_cnt;
        s = cyc;
        start_job(3, 'h20, 0);
        for (int i = 0; i < 4; i++) step();
        n_checks++;
        if (done_cnt - bcnt != 1 || done_cyc < s + 1 || done_cyc > s + 2) begin
            n_fail++;
            $display("FAIL zero_done pulses=%0d cycle=%0d want 1 pulse in %0d..%0d",
                     done_cnt - bcnt, done_cyc, s + 1, s + 2);
        end
        n_checks++;
        if (got_q.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_records records=%0d busy=%b want 0 records, busy 0", got_q.size(), busy);
        end
    endtask

    task automatic test_foreign_id();
        bit ok;
        int bcnt;
        logic [63:0] d;
        clear_obs();
        write_ready = 1'b1;
        bcnt = done_cnt;
        start_job(3, 'h80, 8);
        for (int i = 0; i < 4; i++) begin
            d = {$urandom, $urandom};
            send_beat(5, d);
            d = {$urandom, $urandom};
            beat_q.push_back(d);
            send_beat(3, d);
            if ($urandom % 2) send_beat(5, {$urandom, $urandom});
        end
        wait_done(60, 1'b0, bcnt, ok);
        model_job('h80, 8);
        n_checks++;
        if (!ok || got_q.size() != exp_idx.size()) begin
            n_fail++;
            $display("FAIL foreign_count records=%0d done_seen=%0b want %0d", got_q.size(), ok, exp_idx.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_idx.size(); i++) begin
            n_checks++;
            if (got_q[i].index !== exp_idx[i] || got_q[i].data !== exp_data[i] || got_q[i].cu_id !== 4'd3) begin
                n_fail++;
                $display("FAIL foreign_rec%0d got idx=%h data=%h id=%0d want idx=%h data=%h id=3",
                         i, got_q[i].index, got_q[i].data, got_q[i].cu_id, exp_idx[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_index_wrap();
        bit ok;
        int bcnt;
        int base;
        logic [63:0] d;
        clear_obs();
        write_ready = 1'b1;
        bcnt = done_cnt;
        base = (1 << ARRAY_SIZE_BITS) - 1;
        start_job(3, base, 4);
        for (int i = 0; i < 2; i++) begin
            d = {$urandom, $urandom};
            beat_q.push_back(d);
            send_beat(3, d);
        end
        wait_done(40, 1'b0, bcnt, ok);
        n_checks++;
        if (!ok || got_q.size() != 2 || got_q[0].index !== array_index_t'(base)
            || got_q[1].index !== array_index_t'(1)) begin
            n_fail++;
            $display("FAIL wrap_index records=%0d idx0=%h idx1=%h want 2 records idx %h, 01",
                     got_q.size(), (got_q.size() > 0) ? got_q[0].index : '0,
                     (got_q.size() > 1) ? got_q[1].index : '0, array_index_t'(base));
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int bcnt;
        int base;
        int count;
        int nbeats;
        logic [63:0] d;
        for (int it = 0; it < 6; it++) begin
            clear_obs();
            enabled = 1'b1;
            bcnt = done_cnt;
            base = int'($urandom_range(0, 255));
            count = int'($urandom_range(1, 20));
            nbeats = (count + 1) / 2 + int'($urandom_range(0, 2));
            start_job(3, base, count);
            for (int i = 0; i < nbeats; i++) begin
                d = {$urandom, $urandom};
                beat_q.push_back(d);
                write_ready = 1'($urandom % 2);
                enabled = ($urandom % 4) != 0;
                send_beat(3, d);
                if ($urandom % 3 == 0) step();
            end
            enabled = 1'b1;
            wait_done(400, 1'b1, bcnt, ok);
            model_job(base, count);
            n_checks++;
            if (!ok || got_q.size() != exp_idx.size()) begin
                n_fail++;
                $display("FAIL rand%0d_count records=%0d done_seen=%0b want %0d", it, got_q.size(), ok, exp_idx.size());
            end
            for (int i = 0; i < got_q.size() && i < exp_idx.size(); i++) begin
                n_checks++;
                if (got_q[i].index !== exp_idx[i] || got_q[i].data !== exp_data[i]
                    || got_sz[i] !== 12'(exp_sz[i])) begin
                    n_fail++;
                    $display("FAIL rand%0d_rec%0d got idx=%h data=%h sz=%0d want idx=%h data=%h sz=%0d",
                             it, i, got_q[i].index, got_q[i].data, got_sz[i], exp_idx[i], exp_data[i], exp_sz[i]);
                end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit have_snap;
        bit hold_bad;
        int bcnt;
        int rr_ones;
        DataWrite snap;
        logic [11:0] snap_sz;
        logic [63:0] d;
        clear_obs();
        write_ready = 1'b0;
        bcnt = done_cnt;
        have_snap = 1'b0;
        hold_bad = 1'b0;
        rr_ones = 0;
        snap = '0;
        snap_sz = '0;
        start_job(3, 'h40, 34);
        for (int k = 0; k < 20; k++) begin
            d = {$urandom, $urandom};
            beat_q.push_back(d);
            if (read_ready) rr_ones++;
            read_data_in = '{valid: 1'b1, cu_id: 4'd3, data: d};
            step();
            if (write_data_out.valid) begin
                if (!have_snap) begin
                    have_snap = 1'b1;
                    snap = write_data_out;
                    snap_sz = write_cmd_size;
                end else if (write_data_out !== snap || write_cmd_size !== snap_sz) begin
                    hold_bad = 1'b1;
                end
            end
        end
        read_data_in.valid = 1'b0;
        step();
        n_checks++;
        if (rr_ones != 17 || read_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_read_ready beats_with_ready=%0d rr_now=%b want 17 and 0", rr_ones, read_ready);
        end
        n_checks++;
        if (overflow_error !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_overflow overflow_error=%b want 1", overflow_error);
        end
        n_checks++;
        if (!have_snap || hold_bad || write_data_out !== snap) begin
            n_fail++;
            $display("FAIL bp_hold seen=%0b changed=%0b want held record", have_snap, hold_bad);
        end
        write_ready = 1'b1;
        wait_done(100, 1'b0, bcnt, ok);
        model_job('h40, 34);
        n_checks++;
        if (!ok || got_q.size() != 17) begin
            n_fail++;
            $display("FAIL bp_count records=%0d done_seen=%0b want 17", got_q.size(), ok);
        end
        for (int i = 0; i < got_q.size() && i < exp_idx.size(); i++) begin
            n_checks++;
            if (got_q[i].index !== exp_idx[i] || got_q[i].data !== exp_data[i]) begin
                n_fail++;
                $display("FAIL bp_rec%0d got idx=%h data=%h want idx=%h data=%h",
                         i, got_q[i].index, got_q[i].data, exp_idx[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_reset_mid_job();
        bit ok;
        int bcnt;
        logic [63:0] d;
        clear_obs();
        write_ready = 1'b1;
        start_job(3, 'h30, 8);
        for (int i = 0; i < 4; i++) begin
            send_beat(3, {$urandom, $urandom});
            if (got_q.size() >= 2) break;
        end
        for (int t = 0; t < 10 && got_q.size() < 2; t++) step();
        rstn = 1'b0;
        read_data_in.valid = 1'b0;
        #1;
        n_checks++;
        if (write_data_out !== '0 || write_cmd_size !== 12'd0 || busy !== 1'b0 || done !== 1'b0
            || overflow_error !== 1'b0 || read_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_values wd=%h sz=%0d busy=%b done=%b ovf=%b rr=%b want reset values",
                     write_data_out, write_cmd_size, busy, done, overflow_error, read_ready);
        end
        step(); step();
        rstn = 1'b1;
        bcnt = done_cnt;
        for (int i = 0; i < 10; i++) step();
        n_checks++;
        if (done_cnt != bcnt || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_no_done pulses=%0d busy=%b want 0 pulses, busy 0", done_cnt - bcnt, busy);
        end
        clear_obs();
        start_job(3, 'h50, 2);
        d = {$urandom, $urandom};
        send_beat(3, d);
        wait_done(40, 1'b0, bcnt, ok);
        n_checks++;
        if (!ok || got_q.size() != 1 || got_q[0].index !== 8'h50 || got_q[0].data !== ref_swap(d)) begin
            n_fail++;
            $display("FAIL midreset_new_job records=%0d idx=%h done_seen=%0b want 1 record idx 50",
                     got_q.size(), (got_q.size() > 0) ? got_q[0].index : '0, ok);
        end
    endtask

    initial begin
        rstn             = 1'b0;
        enabled          = 1'b1;
        start            = 1'b0;
        job_cu_id        = '0;
        job_base_index   = '0;
        job_num_elements = '0;
        read_data_in     = '0;
        write_ready      = 1'b1;
        test_reset();
        test_basic();
        test_zero_count();
        test_foreign_id();
        test_index_wrap();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_job();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
